output_divider: RTL and testbench

Final stage of the histogram-equalisation output pipeline. Takes each scaled numerator `(cdf − cdfMin)·255` from the output pipeline as a 28-bit word with a start strobe. Divides it by the pixel-count denominator `(N − cdfMin)` with an 8-iteration restoring divider. Emits the 8-bit equalised pixel value with a one-cycle start strobe.

---
 rtl/output_divider_pkg.sv | 26 ++
 rtl/output_divider_if.sv | 37 +++
 rtl/output_divider_step.sv | 46 ++++
 rtl/output_divider.sv | 135 +++++++++++++
 tb/tb_output_divider.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/output_divider_pkg.sv
//------------------------------------------------------------------------------
// Module   : output_pkg
// Purpose  : Shared widths, state encoding and saturation value for the
//            histogram-equalisation output divider.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package output_pkg;

  localparam int NUM_W = 28;  // scaled numerator (cdf - cdfMin) * 255
  localparam int DEN_W = 20;  // pixel-count denominator N - cdfMin
  localparam int OUT_W = 8;   // equalised pixel width, also iteration count

  localparam logic [7:0] PIX_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/output_divider_if.sv
//------------------------------------------------------------------------------
// Module   : output_divider_if
// Purpose  : Numerator/denominator input handshake and pixel result bus of
//            the output divider.
// Ports    : DataIn, StartIn, Denom (master -> slave)
//            ReadyIn, DataOut, StartOut, Dropped (slave -> master)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface output_divider_if #(
  parameter int NUM_W = output_pkg::NUM_W,
  parameter int DEN_W = output_pkg::DEN_W,
  parameter int OUT_W = output_pkg::OUT_W
);

  logic [NUM_W-1:0] DataIn;
  logic             StartIn;
  logic [DEN_W-1:0] Denom;
  logic             ReadyIn;
  logic [OUT_W-1:0] DataOut;
  logic             StartOut;
  logic             Dropped;

  modport master (
    output DataIn, StartIn, Denom,
    input  ReadyIn, DataOut, StartOut, Dropped
  );

  modport slave (
    input  DataIn, StartIn, Denom,
    output ReadyIn, DataOut, StartOut, Dropped
  );

endinterface

`default_nettype wire

// File: rtl/output_divider_step.sv
//------------------------------------------------------------------------------
// Module   : output_div_step
// Purpose  : One restoring-division step: compare den<<cnt against rem and
//            subtract when it fits. Purely combinational.
// Ports    : rem      in  NUM_W  current partial remainder
//            den      in  DEN_W  divisor
//            cnt      in  CNT_W  bit position being resolved
//            rem_next out NUM_W  remainder after this step
//            q_bit    out 1      quotient bit for position cnt
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module output_div_step #(
  parameter int NUM_W = 28,
  parameter int DEN_W = 20,
  parameter int OUT_W = 8,
  parameter int CNT_W = 3
) (
  input  wire logic [NUM_W-1:0] rem,
  input  wire logic [DEN_W-1:0] den,
  input  wire logic [CNT_W-1:0] cnt,
  output logic      [NUM_W-1:0] rem_next,
  output logic                  q_bit
);

  // Wide enough for both the shifted divisor and the numerator plus one
  // spare bit, so the compare can never wrap.
  localparam int CMP_W = ((NUM_W > DEN_W + OUT_W) ? NUM_W : DEN_W + OUT_W) + 1;

  logic [CMP_W-1:0] shifted_den;
  logic [CMP_W-1:0] rem_ext;
  logic [CMP_W-1:0] diff;

  always_comb begin
    shifted_den = CMP_W'(den) << cnt;
    rem_ext     = CMP_W'(rem);
    diff        = rem_ext - shifted_den;
    q_bit       = (shifted_den <= rem_ext);
    // When the bit is set the difference is below rem, so it fits NUM_W.
    rem_next    = q_bit ? NUM_W'(diff) : rem;
  end

endmodule

`default_nettype wire

// File: rtl/output_divider.sv
//------------------------------------------------------------------------------
// Module   : output_divider
// Purpose  : Final histogram-equalisation stage. Divides the scaled numerator
//            by (N - cdfMin) with an OUT_W-iteration restoring divider and
//            emits the equalised pixel with a one-cycle strobe. Quotients that
//            cannot fit, or a zero denominator, saturate to all ones.
// Ports    : clock, reset (sync, active-high)
//            bus (output_divider_if.slave): DataIn, StartIn, Denom, ReadyIn,
//            DataOut, StartOut, Dropped
// Config   : OUTPUT_DIVIDER_ROUND_EN - round-half-up in DONE (saturating);
//            undefined gives a truncating quotient.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module output_divider #(
  parameter int NUM_W = output_pkg::NUM_W,
  parameter int DEN_W = output_pkg::DEN_W,
  parameter int OUT_W = output_pkg::OUT_W
) (
  input  wire logic          clock,
  input  wire logic          reset,
  output_divider_if.slave    bus
);

  import output_pkg::*;

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int CMP_W = ((NUM_W > DEN_W + OUT_W) ? NUM_W : DEN_W + OUT_W) + 1;
  localparam logic [OUT_W-1:0] SAT_VAL = {OUT_W{1'b1}};

  div_state_t       state;
  logic [NUM_W-1:0] rem;
  logic [DEN_W-1:0] den;
  logic [OUT_W-1:0] quot;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] data_out;
  logic             start_out;
  logic             dropped;

  logic [NUM_W-1:0] step_rem;
  logic             step_q;
  logic             overflow;
  logic [OUT_W-1:0] final_quot;

  output_div_step #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_step (
    .rem      (rem),
    .den      (den),
    .cnt      (cnt),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Quotient would need more than OUT_W bits (or divisor is zero).
  assign overflow = (bus.Denom == '0) ||
                    (CMP_W'(bus.DataIn) >= (CMP_W'(bus.Denom) << OUT_W));

`ifdef OUTPUT_DIVIDER_ROUND_EN
  logic round_up;
  // A saturated quotient is already all ones, so the saturating increment
  // leaves that path unrounded without a separate flag.
  assign round_up   = ((CMP_W'(rem) << 1) >= CMP_W'(den)) && (quot != SAT_VAL);
  assign final_quot = round_up ? quot + OUT_W'(1) : quot;
`else
  assign final_quot = quot;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      den       <= '0;
      quot      <= '0;
      cnt       <= '0;
      data_out  <= '0;
      start_out <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      // Result bus is only non-zero during the strobe cycle.
      start_out <= 1'b0;
      data_out  <= '0;

      if (bus.StartIn && (state != IDLE)) begin
        dropped <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.StartIn) begin
            rem <= bus.DataIn;
            den <= bus.Denom;
            if (overflow) begin
              quot  <= SAT_VAL;
              state <= DONE;
            end else begin
              quot  <= '0;
              cnt   <= CNT_W'(OUT_W - 1);
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= step_rem;
          if (step_q) begin
            quot[cnt] <= 1'b1;
          end
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          data_out  <= final_quot;
          start_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ReadyIn  = (state == IDLE);
  assign bus.DataOut  = data_out;
  assign bus.StartOut = start_out;
  assign bus.Dropped  = dropped;

endmodule

`default_nettype wire

// File: tb/tb_output_divider.sv
//------------------------------------------------------------------------------
// Module   : tb_output_divider
// Purpose  : Directed, table-driven bench for output_divider plus hand-written
//            sequences for back-to-back, overrun and mid-division reset.
// Config   : OUTPUT_DIVIDER_ROUND_EN selects rounded expected values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_divider;

  import output_pkg::*;

  logic clock;
  logic reset;

  output_divider_if bus ();

  output_divider dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  typedef struct {
    logic [27:0] d;
    logic [19:0] dn;
    logic [7:0]  exp_t;  // truncating result
    logic [7:0]  exp_r;  // round-half-up result
    int          lat;    // cycles from accept edge to StartOut
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with ReadyIn high; returns at the negedge where
  // StartOut is high. drop_at >= 0 pulses StartIn at that busy cycle.
  task automatic do_word(input logic [27:0] d, input logic [19:0] dn,
                         input int drop_at, output int lat, output int busy,
                         output logic [7:0] val);
    int k;
    k    = 0;
    busy = 0;
    bus.DataIn  = d;
    bus.Denom   = dn;
    bus.StartIn = 1'b1;
    @(negedge clock);
    bus.StartIn = 1'b0;
    while (!bus.StartOut && k < 30) begin
      if (!bus.ReadyIn) busy++;
      bus.StartIn = (k == drop_at);
      @(negedge clock);
      k++;
    end
    bus.StartIn = 1'b0;
    if (!bus.StartOut) chk("result_timeout", 0, 1);
    lat = k;
    val = bus.DataOut;
  endtask

  initial begin
    int          lat;
    int          busy;
    logic [7:0]  val;
    logic [7:0]  exp;
    int          seen;

    checks = 0;
    errors = 0;

    //            data        denom     trunc  round  lat
    vecs[0]  = '{28'd127500,    20'd1000,    8'd127, 8'd128, 9};
    vecs[1]  = '{28'd255000,    20'd1000,    8'd255, 8'd255, 9};
    vecs[2]  = '{28'd300000,    20'd1000,    8'd255, 8'd255, 1};
    vecs[3]  = '{28'd5,         20'd0,       8'd255, 8'd255, 1};
    vecs[4]  = '{28'd2550,      20'd10,      8'd255, 8'd255, 9};
    vecs[5]  = '{28'd100,       20'd7,       8'd14,  8'd14,  9};
    vecs[6]  = '{28'd0,         20'd1000,    8'd0,   8'd0,   9};
    vecs[7]  = '{28'd1023,      20'd4,       8'd255, 8'd255, 9};
    vecs[8]  = '{28'd999,       20'd1000,    8'd0,   8'd1,   9};
    vecs[9]  = '{28'd256,       20'd1,       8'd255, 8'd255, 1};
    vecs[10] = '{28'd255,       20'd1,       8'd255, 8'd255, 9};
    vecs[11] = '{28'd268435455, 20'd1048575, 8'd255, 8'd255, 1};
    vecs[12] = '{28'd134217727, 20'd1048575, 8'd128, 8'd128, 9};

    bus.DataIn  = '0;
    bus.Denom   = '0;
    bus.StartIn = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clock);

    chk("reset_DataOut",  bus.DataOut,  0);
    chk("reset_StartOut", bus.StartOut, 0);
    chk("reset_ReadyIn",  bus.ReadyIn,  1);
    chk("reset_Dropped",  bus.Dropped,  0);

    reset = 1'b0;
    @(negedge clock);

    // Table vectors, each issued back-to-back with the previous result.
    for (int i = 0; i < 13; i++) begin
`ifdef OUTPUT_DIVIDER_ROUND_EN
      exp = vecs[i].exp_r;
`else
      exp = vecs[i].exp_t;
`endif
      chk($sformatf("ready_v%0d", i), bus.ReadyIn, 1);
      do_word(vecs[i].d, vecs[i].dn, -1, lat, busy, val);
      chk($sformatf("data_v%0d", i), val, exp);
      chk($sformatf("lat_v%0d", i), lat, vecs[i].lat);
      chk($sformatf("busy_v%0d", i), busy, vecs[i].lat);
    end
    chk("no_drop_after_table", bus.Dropped, 0);

    // Back-to-back: second word lands in the StartOut cycle of the first.
    @(negedge clock);
    do_word(28'd127500, 20'd1000, -1, lat, busy, val);
    do_word(28'd100, 20'd7, -1, lat, busy, val);
    chk("b2b_gap", lat + 1, 10);
    chk("b2b_data", val, 14);
    chk("b2b_no_drop", bus.Dropped, 0);

    // Overrun: extra StartIn 3 cycles after accept is discarded.
    @(negedge clock);
    do_word(28'd2550, 20'd10, 3, lat, busy, val);
    chk("ovr_data", val, 255);
    chk("ovr_lat", lat, 9);
    chk("ovr_dropped", bus.Dropped, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (bus.StartOut) seen++;
    end
    chk("ovr_single_result", seen, 0);
    do_word(28'd100, 20'd7, -1, lat, busy, val);
    chk("ovr_clean_data", val, 14);
    chk("ovr_dropped_sticky", bus.Dropped, 1);

    // Reset during the fourth DIV cycle aborts the word.
    @(negedge clock);
    bus.DataIn  = 28'd127500;
    bus.Denom   = 20'd1000;
    bus.StartIn = 1'b1;
    @(negedge clock);
    bus.StartIn = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_busy", bus.ReadyIn, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_ReadyIn", bus.ReadyIn, 1);
    chk("mid_DataOut", bus.DataOut, 0);
    chk("mid_StartOut", bus.StartOut, 0);
    chk("mid_Dropped", bus.Dropped, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (bus.StartOut) seen++;
    end
    chk("mid_no_result", seen, 0);

    // Still functional after the abort.
    do_word(28'd300000, 20'd1000, -1, lat, busy, val);
    chk("post_reset_data", val, 255);
    chk("post_reset_lat", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
